instr_fetch_unit: RTL

- Fetch stage directly upstream of the decode/control/datapath core.
- Generates the sequential PC and issues word requests to instruction memory over a req/gnt/rvalid protocol.
- Buffers returned words with their PC in a small prefetch FIFO and presents them to decode over a valid/ready handshake.
- Discards in-flight and buffered fetches when a branch/jump redirect arrives.

---
 rtl/instr_fetch_unit.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage that feeds decode. It walks a sequential PC and issues one
//   word request at a time to instruction memory (req/gnt/rvalid, at most one
//   request outstanding). Returned words are queued with their PC in a small
//   prefetch FIFO and handed to decode over a valid/ready handshake. A taken
//   branch or jump (redirect) flushes the FIFO and discards any fetch that is
//   already in flight.
//
//   Optional feature macro: FETCH_BYPASS_EN
//     When defined, a word returned while the FIFO is empty goes straight to
//     the decode outputs in the rvalid cycle, which saves one cycle of latency.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active low
//   imem_req       out  fetch request, held until imem_gnt
//   imem_addr      out  word-aligned fetch address
//   imem_gnt       in   request accepted this cycle
//   imem_rvalid    in   read data valid
//   imem_rdata     in   returned instruction word
//   instr_valid    out  instr_code/instr_pc hold a valid entry
//   instr_ready    in   decode consumes the entry when instr_valid is high
//   instr_code     out  instruction word
//   instr_pc       out  PC of instr_code
//   redirect_valid in   branch/jump taken; flush and refetch
//   redirect_pc    in   new fetch target (bits [1:0] ignored)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_code,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DISCARD} state_e;

  state_e        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;     // address of the request on the bus
  logic          drop_q, drop_d;     // redirect seen while the old request waits for gnt
  logic [CW-1:0] count_q, count_d, cnt_after;
  logic [PW-1:0] wr_q, rd_q;
  logic [31:0]   code_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];

  logic [31:0]   rpc;
  logic          rvalid_take, byp, push, fifo_pop;

  assign rpc         = redirect_pc & ~32'h3;
  assign rvalid_take = (state_q == WAIT) && imem_rvalid && !redirect_valid;

`ifdef FETCH_BYPASS_EN
  assign byp = rvalid_take && (count_q == '0);
`else
  assign byp = 1'b0;
`endif

  // A bypassed word that decode accepts immediately never enters the FIFO.
  assign push      = rvalid_take && !(byp && instr_ready);
  assign fifo_pop  = (count_q != '0) && instr_ready;
  assign cnt_after = count_q + CW'(push) - CW'(fifo_pop);
  assign count_d   = cnt_after;

  assign imem_req    = (state_q == REQ);
  assign imem_addr   = addr_q;
  assign instr_valid = (count_q != '0) || byp;
  assign instr_code  = byp ? imem_rdata : code_mem[rd_q];
  assign instr_pc    = byp ? addr_q     : pc_mem[rd_q];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    drop_d     = drop_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid)          fetch_pc_d = rpc;
        else if (count_q < DEPTH_C)  state_d    = REQ;
      end
      REQ: begin
        if (imem_gnt) begin
          if (redirect_valid || drop_q) begin
            state_d = DISCARD;
            drop_d  = 1'b0;
            if (redirect_valid) fetch_pc_d = rpc;
          end else begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = WAIT;
          end
        end else if (redirect_valid) begin
          // Request must stay on the bus until granted; remember to drop it.
          fetch_pc_d = rpc;
          drop_d     = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = rpc;
          state_d    = imem_rvalid ? IDLE : DISCARD;
        end else if (imem_rvalid) begin
          state_d = (cnt_after < DEPTH_C) ? REQ : IDLE;
        end
      end
      DISCARD: begin
        if (redirect_valid) fetch_pc_d = rpc;
        if (imem_rvalid)    state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Latch the bus address only on entry so it is stable until gnt.
    if (state_d == REQ && state_q != REQ) addr_d = fetch_pc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        code_mem[i] <= '0;
        pc_mem[i]   <= '0;
      end
    end else if (redirect_valid) begin
      count_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      if (push) begin
        code_mem[wr_q] <= imem_rdata;
        pc_mem[wr_q]   <= addr_q;
        wr_q           <= wr_q + PW'(1);
      end
      if (fifo_pop) rd_q <= rd_q + PW'(1);
      count_q <= count_d;
    end
  end

endmodule
